sys_rst_seq: RTL



---
 rtl/sys_rst_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sys_rst_seq.sv
// sys_rst_seq: PLL bring-up and staggered multi-domain reset sequencer
// Ports: ext_clk/ext_rst_n board clock and async active-low reset; dom_clk per-domain clocks;
// pll_locked raw lock; pll_areset PLL reset; dom_rst_n per-domain resets; sys_ready all released;
// pll_fail sticky retry exhaustion; state FSM state; lock_loss_cnt saturating lock-loss count.
module sys_rst_seq #(
  parameter int N_DOM            = 5,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STAGGER_CYC      = 4,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 16
) (
  input  logic             ext_clk,
  input  logic             ext_rst_n,
  input  logic [N_DOM-1:0] dom_clk,
  input  logic             pll_locked,
  output logic             pll_areset,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             sys_ready,
  output logic             pll_fail,
  output logic [2:0]       state,
  output logic [7:0]       lock_loss_cnt
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {PLL_RST = 3'd0, WAIT_LOCK = 3'd1, RELEASE = 3'd2, RUN = 3'd3, FAIL = 3'd4} state_t;
  state_t state_q, state_d;
  logic [1:0] rst_sync_q, lock_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, stable_q, stable_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [N_DOM-1:0] rel_req_q, rel_req_d;
  logic [7:0] lock_loss_q, lock_loss_d;
  logic pll_areset_q, pll_areset_d, sys_ready_q, sys_ready_d, pll_fail_q, pll_fail_d;
  logic lock_s;
  assign lock_s = lock_sync_q[1];
  always_ff @(posedge ext_clk or negedge ext_rst_n)
    if (!ext_rst_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      lock_sync_q <= {lock_sync_q[0], pll_locked};
    end
  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == RUN || state_q == FAIL) ? cnt_q : cnt_q + 1'b1;
    stable_d    = (state_q == WAIT_LOCK && lock_s) ? stable_q + 1'b1 : '0;
    retry_d     = retry_q;
    rel_req_d   = rel_req_q;
    lock_loss_d = lock_loss_q;
    case (state_q)
      PLL_RST: state_d = (cnt_q == CNT_W'(PLL_RST_CYC - 1)) ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK:
        if (lock_s && stable_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
          state_d = RELEASE;
          retry_d = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
          state_d = (retry_q < RW'(MAX_RETRY)) ? PLL_RST : FAIL;
          retry_d = (retry_q < RW'(MAX_RETRY)) ? retry_q + 1'b1 : retry_q;
        end
      RELEASE: begin
        for (int i = 0; i < N_DOM; i++)
          if (cnt_q == CNT_W'(i * STAGGER_CYC)) rel_req_d[i] = 1'b1;
        // the last request was set on the previous edge
        if (cnt_q == CNT_W'((N_DOM - 1) * STAGGER_CYC + 1)) state_d = RUN;
      end
      RUN, FAIL: ;
      default: state_d = PLL_RST;
    endcase
    // lock loss restarts the PLL without spending a retry
    if ((state_q == RELEASE || state_q == RUN) && !lock_s) begin
      state_d     = PLL_RST;
      rel_req_d   = '0;
      lock_loss_d = lock_loss_q + {7'd0, lock_loss_q != 8'hff};
    end
    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
    end
    // hold everything at reset values until the synchronised reset releases
    if (!rst_sync_q[1]) begin
      state_d     = PLL_RST;
      cnt_d       = '0;
      stable_d    = '0;
      retry_d     = '0;
      rel_req_d   = '0;
      lock_loss_d = '0;
    end
    pll_areset_d = state_d == PLL_RST || state_d == FAIL;
    sys_ready_d  = state_d == RUN;
    pll_fail_d   = state_d == FAIL;
  end
  always_ff @(posedge ext_clk or negedge ext_rst_n)
    if (!ext_rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      stable_q     <= '0;
      retry_q      <= '0;
      rel_req_q    <= '0;
      lock_loss_q  <= '0;
      pll_areset_q <= 1'b1;
      sys_ready_q  <= 1'b0;
      pll_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      retry_q      <= retry_d;
      rel_req_q    <= rel_req_d;
      lock_loss_q  <= lock_loss_d;
      pll_areset_q <= pll_areset_d;
      sys_ready_q  <= sys_ready_d;
      pll_fail_q   <= pll_fail_d;
    end
  // rel_req is registered, so using it as an async clear is glitch-free
  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    logic [1:0] sync_q;
    always_ff @(posedge dom_clk[i] or negedge rel_req_q[i])
      if (!rel_req_q[i]) sync_q <= '0;
      else sync_q <= {sync_q[0], 1'b1};
    assign dom_rst_n[i] = sync_q[1];
  end
  assign pll_areset    = pll_areset_q;
  assign sys_ready     = sys_ready_q;
  assign pll_fail      = pll_fail_q;
  assign state         = state_q;
  assign lock_loss_cnt = lock_loss_q;
endmodule
